isp_thresh_ctrl: RTL and testbench
==================================

Name: isp_thresh_ctrl

Overview:
Frame-synchronous binarisation-threshold controller for the ISP chain. It taps the Gaussian-filtered gray stream (vsync/de/8-bit pixel) and accumulates the luminance sum and pixel count per frame. In the vertical blanking interval it computes the frame mean with a serial divider, applies a signed offset, clamping and optional IIR smoothing, and drives the threshold consumed by the binariser. The threshold changes only at frame boundaries, so a frame is never binarised with two different thresholds.

Parameters:
SUM_W, 32, pixel-sum accumulator width (saturating)
CNT_W, 22, pixel-count accumulator width (saturating)
VS_POL, 1, vsync_i active level (1 = active-high)
THR_INIT, 8'd128, threshold_o value at reset
THR_MIN, 8'd16, lower clamp for auto threshold
THR_MAX, 8'd240, upper clamp for auto threshold
SMOOTH_SH, 2, IIR shift; 0 = no smoothing

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset
vsync_i  in  1  frame sync, polarity set by VS_POL
de_i  in  1  pixel valid
gray_i  in  8  filtered gray pixel
auto_en  in  1  1 = auto threshold, 0 = manual
thr_manual  in  8  manual threshold
thr_offset  in  8  signed two's-complement offset added to the mean
threshold_o  out  8  active threshold
thr_upd  out  1  one-cycle pulse when threshold_o is written
frame_mean_o  out  8  last computed frame mean
busy_o  out  1  high while DIV or CALC is active
err_o  out  1  one-cycle pulse: empty frame, saturation or aborted division

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset: threshold_o = THR_INIT, frame_mean_o = 0, thr_upd = 0, busy_o = 0, err_o = 0, accumulators cleared, armed = 0, state = ACCUM.
- Input stage: vsync_i, de_i and gray_i are registered once (stage d1). Frame edge = d1 active while d2 inactive.
- Accumulation: every d1 cycle with de high adds gray to sum and 1 to cnt. Both accumulators saturate; any saturation sets a per-frame sat flag.
- Frame edge (edge cycle, all actions in the same cycle):
  - latch sum, cnt and sat into the divider operands;
  - clear the accumulators, or load them with the current pixel if d1 de is high (that pixel belongs to the new frame);
  - if armed = 0: set armed = 1 and start no division (first, partial frame after reset is discarded);
  - else enter DIV.
- FSM states and transitions:
  - ACCUM: idle/accumulating; goes to DIV on an armed frame edge.
  - DIV: 8 cycles, restoring divide, quotient bits 7 down to 0: if rem >= (cnt << i) then rem -= (cnt << i) and q[i] = 1. The result is floor(sum/cnt) and is guaranteed 8-bit.
  - CALC: 1 cycle.
  - UPD: 1 cycle, writes outputs, pulses thr_upd, returns to ACCUM.
  - Accumulation runs continuously in every state.
- CALC arithmetic:
  - frame_mean_o <= q.
  - Target = clamp(q + sext(thr_offset), THR_MIN, THR_MAX), computed in 10-bit signed.
  - If SMOOTH_SH > 0: new = old + ((target − old) >>> SMOOTH_SH), arithmetic shift, 10-bit signed; else new = target.
  - auto_en and thr_manual are sampled in CALC only. If auto_en = 0, new = thr_manual (unclamped, unsmoothed).
- Latency: call the clk edge that first samples vsync_i active edge 0. The frame edge is detected at edge 1, DIV runs edges 2–9, CALC at edge 10, UPD at edge 11. threshold_o changes at edge 11 and thr_upd is high for the following cycle.
- cnt == 0 (empty frame) or sat == 1: skip DIV. In CALC, err_o pulses, threshold_o and frame_mean_o hold, and no thr_upd is issued. In manual mode the manual value is still written.
- Frame edge while busy (DIV or CALC): the in-flight result is discarded, err_o pulses, and the divider restarts with the new operands.
- Mid-frame changes to auto_en, thr_manual or thr_offset have no effect until the next CALC.
- Reset mid-frame or mid-division returns to reset state; the next frame edge only arms.

Decomposition:
- Shared package isp_pkg: state encoding (ACCUM, DIV, CALC, UPD), default constants THR_INIT/THR_MIN/THR_MAX, and a clamp function.
- One sub-module, isp_serial_div8: start/done handshake, SUM_W / CNT_W operands, 8-bit quotient, fixed 8 cycles, abort input.

Test Plan:
- Reset, then two 4×4 frames of gray = 100, thr_offset = −20 (8'hEC), SMOOTH_SH = 0, auto_en = 1 -> first edge arms only; at second edge: frame_mean_o = 100, threshold_o = 80 exactly 11 edges after sampling, thr_upd one cycle.
- Frame alternating pixels 10 and 30, thr_offset = 0 -> mean 20, threshold_o = 20. Same with pixels 0 and 10 -> threshold clamped to THR_MIN = 16.
- SMOOTH_SH = 2, threshold_o = 128, frames of mean 200, offset 0 -> successive thresholds 146, 159, 169.
- Frame with de_i never high -> err_o pulse, threshold_o and frame_mean_o unchanged, no thr_upd.
- auto_en = 0, thr_manual = 55, toggled mid-frame -> threshold_o = 55 only at the UPD of the next frame edge, no earlier change.
- Frame edge injected 4 cycles into DIV -> err_o pulses, old result discarded, new frame's mean written 11 edges after the new edge. Then rst_n asserted mid-DIV -> threshold_o = 128 immediately, next edge produces no update.

Source files
------------

// File: rtl/isp_pkg.sv
// isp_pkg: shared FSM encoding, default threshold constants and the clamp
// helper used by the ISP binarisation-threshold controller.
package isp_pkg;

    // Controller states; the encoding is also visible as the top's state signal.
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DIV   = 2'd1,
        CALC  = 2'd2,
        UPD   = 2'd3
    } thr_state_t;

    localparam logic [7:0] THR_INIT_DEF = 8'd128;
    localparam logic [7:0] THR_MIN_DEF  = 8'd16;
    localparam logic [7:0] THR_MAX_DEF  = 8'd240;

    // Clamp a 10-bit signed value into the unsigned range [lo, hi].
    function automatic logic [7:0] clamp_thr(input logic signed [9:0] value,
                                             input logic [7:0]        lo,
                                             input logic [7:0]        hi);
        logic [7:0] result;
        if (value < $signed({2'b00, lo})) begin
            result = lo;
        end else if (value > $signed({2'b00, hi})) begin
            result = hi;
        end else begin
            result = value[7:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/isp_serial_div8.sv
// isp_serial_div8: restoring serial divider producing an 8-bit quotient
// in exactly 8 cycles. The caller guarantees dividend < 256 * divisor.
//
// Handshake: start is a single-cycle request; dividend and divisor are
// captured on that edge and a start always restarts the divider, even
// mid-division. done is high during the cycle whose closing clock edge
// resolves quotient bit 0; quotient is valid from the next cycle until
// the following start. abort (ignored when start is high) drops an
// in-flight division without producing done.
module isp_serial_div8 #(
    parameter int SUM_W = 32,
    parameter int CNT_W = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [7:0]       quotient,
    output logic             done
);

    localparam int W = SUM_W + 8;

    logic [SUM_W-1:0] rem;
    logic [CNT_W-1:0] dvs;
    logic [2:0]       bit_idx;
    logic             running;
    logic [W-1:0]     shifted;
    logic             fits;

    assign shifted = {{(W - CNT_W){1'b0}}, dvs} << bit_idx;
    assign fits    = {8'd0, rem} >= shifted;
    assign done    = running && (bit_idx == 3'd0);

    // One quotient bit per cycle, MSB first; start wins over abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dvs      <= '0;
            bit_idx  <= 3'd0;
            running  <= 1'b0;
            quotient <= 8'd0;
        end else if (start) begin
            rem      <= dividend;
            dvs      <= divisor;
            bit_idx  <= 3'd7;
            running  <= 1'b1;
            quotient <= 8'd0;
        end else if (abort) begin
            running <= 1'b0;
        end else if (running) begin
            if (fits) begin
                rem <= rem - shifted[SUM_W-1:0];
            end
            quotient[bit_idx] <= fits;
            if (bit_idx == 3'd0) begin
                running <= 1'b0;
            end else begin
                bit_idx <= bit_idx - 3'd1;
            end
        end
    end

endmodule

// File: rtl/isp_thresh_ctrl.sv
// isp_thresh_ctrl: per-frame mean luminance -> binarisation threshold.
// Pixels are summed during the frame; at each frame edge the previous
// frame's totals are divided, offset, clamped, optionally smoothed and
// written to threshold_o, so the threshold only moves between frames.
module isp_thresh_ctrl
    import isp_pkg::*;
#(
    parameter int         SUM_W     = 32,
    parameter int         CNT_W     = 22,
    parameter bit         VS_POL    = 1'b1,
    parameter logic [7:0] THR_INIT  = THR_INIT_DEF,
    parameter logic [7:0] THR_MIN   = THR_MIN_DEF,
    parameter logic [7:0] THR_MAX   = THR_MAX_DEF,
    parameter int         SMOOTH_SH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync_i,
    input  logic       de_i,
    input  logic [7:0] gray_i,
    input  logic       auto_en,
    input  logic [7:0] thr_manual,
    input  logic [7:0] thr_offset,
    output logic [7:0] threshold_o,
    output logic       thr_upd,
    output logic [7:0] frame_mean_o,
    output logic       busy_o,
    output logic       err_o
);

    thr_state_t state, next_state;

    logic             vs_d1, vs_d2, de_d1;
    logic [7:0]       gray_d1;
    logic             frame_edge, edge_go, frame_bad, busy;
    logic [SUM_W-1:0] sum_acc;
    logic [CNT_W-1:0] cnt_acc;
    logic             sat_acc;
    logic [SUM_W:0]   sum_add;
    logic [CNT_W:0]   cnt_add;
    logic             armed, calc_bad;
    logic             div_start, div_abort, div_done;
    logic [7:0]       div_q;
    logic [7:0]       new_thr, target, calc_thr;
    logic signed [9:0] mean_s, off_s, sum_s, diff_s, smooth_s;

    // Register the video tap once; vsync is normalised to active-high here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d1   <= 1'b0;
            vs_d2   <= 1'b0;
            de_d1   <= 1'b0;
            gray_d1 <= 8'd0;
        end else begin
            vs_d1   <= (vsync_i == VS_POL);
            vs_d2   <= vs_d1;
            de_d1   <= de_i;
            gray_d1 <= gray_i;
        end
    end

    assign frame_edge = vs_d1 && !vs_d2;
    assign edge_go    = frame_edge && armed;
    assign frame_bad  = (cnt_acc == '0) || sat_acc;
    assign busy       = (state == DIV) || (state == CALC);
    assign busy_o     = busy;

    assign sum_add = {1'b0, sum_acc} + {{(SUM_W - 7){1'b0}}, gray_d1};
    assign cnt_add = {1'b0, cnt_acc} + {{CNT_W{1'b0}}, 1'b1};

    // Saturating frame accumulators; an edge-cycle pixel seeds the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_acc <= '0;
            cnt_acc <= '0;
            sat_acc <= 1'b0;
        end else if (frame_edge) begin
            sum_acc <= de_d1 ? {{(SUM_W - 8){1'b0}}, gray_d1} : '0;
            cnt_acc <= de_d1 ? {{(CNT_W - 1){1'b0}}, 1'b1} : '0;
            sat_acc <= 1'b0;
        end else if (de_d1) begin
            sum_acc <= sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
            cnt_acc <= cnt_add[CNT_W] ? '1 : cnt_add[CNT_W-1:0];
            sat_acc <= sat_acc || sum_add[SUM_W] || cnt_add[CNT_W];
        end
    end

    // The first frame after reset is partial, so its edge only arms; the
    // bad-frame flag travels with the frame into CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            calc_bad <= 1'b0;
        end else if (frame_edge) begin
            armed <= 1'b1;
            if (armed) begin
                calc_bad <= frame_bad;
            end
        end
    end

    isp_serial_div8 #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (sum_acc),
        .divisor  (cnt_acc),
        .quotient (div_q),
        .done     (div_done)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Next state and divider control; an armed frame edge overrides
    // whatever was in flight.
    always_comb begin
        next_state = state;
        div_start  = 1'b0;
        div_abort  = 1'b0;
        case (state)
            ACCUM:   next_state = ACCUM;
            DIV:     if (div_done) next_state = CALC;
            CALC:    next_state = (calc_bad && auto_en) ? ACCUM : UPD;
            UPD:     next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
        if (edge_go) begin
            if (frame_bad) begin
                div_abort  = 1'b1;
                next_state = CALC;
            end else begin
                div_start  = 1'b1;
                next_state = DIV;
            end
        end
    end

    assign mean_s   = {2'b00, div_q};
    assign off_s    = {{2{thr_offset[7]}}, thr_offset};
    assign sum_s    = mean_s + off_s;
    assign target   = clamp_thr(sum_s, THR_MIN, THR_MAX);
    assign diff_s   = $signed({2'b00, target}) - $signed({2'b00, threshold_o});
    assign smooth_s = $signed({2'b00, threshold_o}) + (diff_s >>> SMOOTH_SH);
    assign calc_thr = auto_en ? smooth_s[7:0] : thr_manual;

    // Result registers: CALC stages the new threshold, UPD publishes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            threshold_o  <= THR_INIT;
            frame_mean_o <= 8'd0;
            new_thr      <= THR_INIT;
            thr_upd      <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            thr_upd <= 1'b0;
            err_o   <= 1'b0;
            if (edge_go && busy) begin
                err_o <= 1'b1;
            end
            if ((state == CALC) && !edge_go) begin
                if (calc_bad) begin
                    err_o <= 1'b1;
                end else begin
                    frame_mean_o <= div_q;
                end
                new_thr <= calc_thr;
            end
            if (state == UPD) begin
                threshold_o <= new_thr;
                thr_upd     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_isp_thresh_ctrl.sv
// tb_isp_thresh_ctrl: two controllers (no smoothing / shift-2 smoothing)
// share one video stream; a frame-level model predicts every output.
module tb_isp_thresh_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync_i = 1'b0;
    logic       de_i = 1'b0;
    logic [7:0] gray_i = 8'd0;
    logic       auto_en = 1'b1;
    logic [7:0] thr_manual = 8'd0;
    logic [7:0] thr_offset = 8'd0;

    logic [7:0] thr_o [2];
    logic [7:0] mean_o [2];
    logic       upd_o [2];
    logic       busy_o [2];
    logic       err_o [2];

    int sh_of [2] = '{0, 2};

    isp_thresh_ctrl #(.SMOOTH_SH(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync_i), .de_i(de_i), .gray_i(gray_i),
        .auto_en(auto_en), .thr_manual(thr_manual), .thr_offset(thr_offset),
        .threshold_o(thr_o[0]), .thr_upd(upd_o[0]), .frame_mean_o(mean_o[0]),
        .busy_o(busy_o[0]), .err_o(err_o[0])
    );

    isp_thresh_ctrl #(.SMOOTH_SH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync_i), .de_i(de_i), .gray_i(gray_i),
        .auto_en(auto_en), .thr_manual(thr_manual), .thr_offset(thr_offset),
        .threshold_o(thr_o[1]), .thr_upd(upd_o[1]), .frame_mean_o(mean_o[1]),
        .busy_o(busy_o[1]), .err_o(err_o[1])
    );

    // ---------------- clock / cycle counter / input sampling
    always #5 clk = ~clk;

    int         cyc = 0;
    logic       smp_auto;
    logic [7:0] smp_man, smp_off;

    always @(posedge clk) begin
        cyc      = cyc + 1;
        smp_auto = auto_en;
        smp_man  = thr_manual;
        smp_off  = thr_offset;
    end

    // ---------------- bookkeeping
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (frame level)
    typedef struct {
        int e;
        int sum;
        int cnt;
    } frame_t;

    frame_t fq[$];
    frame_t cf;

    int m_thr [2];
    int m_mean [2];
    int m_new [2];
    bit m_armed;
    bit p_act;
    bit p_bad;
    int p_s;
    int p_q;
    bit edge_now;
    bit exp_upd, exp_err, exp_busy;

    int upd_seen0 = 0;
    int err_seen = 0;
    int last_upd_cyc0 = -1;
    int upd_log1[$];

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic int target_of(input int mean, input logic [7:0] off);
        int t;
        t = mean + int'($signed(off));
        if (t < 16) t = 16;
        if (t > 240) t = 240;
        return t;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_thr[k]  = 128;
            m_mean[k] = 0;
            m_new[k]  = 128;
        end
        m_armed = 1'b0;
        p_act   = 1'b0;
        p_bad   = 1'b0;
        p_s     = 0;
        p_q     = 0;
    endtask

    // Compare process: advance the model one cycle, then check both DUTs.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            exp_upd = 1'b0;
            exp_err = 1'b0;
            if (!rst_n) begin
                model_reset();
                fq.delete();
            end else begin
                edge_now = (fq.size() > 0) && (fq[0].e + 1 == cyc);
                // a new armed frame edge while dividing/calculating drops the old result
                if (edge_now && m_armed && p_act &&
                    ((!p_bad && cyc >= p_s + 1 && cyc <= p_s + 9) || (p_bad && cyc == p_s + 1))) begin
                    exp_err = 1'b1;
                    p_act   = 1'b0;
                end
                if (p_act) begin
                    if (!p_bad) begin
                        if (cyc == p_s + 9) begin
                            for (int k = 0; k < 2; k++) begin
                                m_mean[k] = p_q;
                                if (smp_auto)
                                    m_new[k] = m_thr[k] + floor_div(target_of(p_q, smp_off) - m_thr[k], 1 << sh_of[k]);
                                else
                                    m_new[k] = smp_man;
                            end
                        end else if (cyc == p_s + 10) begin
                            for (int k = 0; k < 2; k++) m_thr[k] = m_new[k];
                            exp_upd = 1'b1;
                            p_act   = 1'b0;
                        end
                    end else begin
                        if (cyc == p_s + 1) begin
                            exp_err = 1'b1;
                            if (smp_auto) p_act = 1'b0;
                            else for (int k = 0; k < 2; k++) m_new[k] = smp_man;
                        end else if (cyc == p_s + 2) begin
                            for (int k = 0; k < 2; k++) m_thr[k] = m_new[k];
                            exp_upd = 1'b1;
                            p_act   = 1'b0;
                        end
                    end
                end
                if (edge_now) begin
                    cf = fq.pop_front();
                    if (!m_armed) begin
                        m_armed = 1'b1;
                    end else begin
                        p_act = 1'b1;
                        p_s   = cyc;
                        p_bad = (cf.cnt == 0);
                        p_q   = p_bad ? 0 : cf.sum / cf.cnt;
                    end
                end
            end
            exp_busy = p_act && ((!p_bad && cyc >= p_s && cyc <= p_s + 8) || (p_bad && cyc == p_s));
            for (int k = 0; k < 2; k++) begin
                check($sformatf("threshold[%0d]", k), thr_o[k], m_thr[k]);
                check($sformatf("frame_mean[%0d]", k), mean_o[k], m_mean[k]);
                check($sformatf("thr_upd[%0d]", k), upd_o[k], exp_upd);
                check($sformatf("err[%0d]", k), err_o[k], exp_err);
                check($sformatf("busy[%0d]", k), busy_o[k], exp_busy);
            end
            if (upd_o[0]) begin
                upd_seen0++;
                last_upd_cyc0 = cyc;
            end
            if (err_o[0]) err_seen++;
            if (upd_o[1]) upd_log1.push_back(thr_o[1]);
        end
    end

    // ---------------- driver tasks
    int cur_sum = 0;
    int cur_cnt = 0;
    int last_e = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        de_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pixel(input logic [7:0] g);
        de_i    = 1'b1;
        gray_i  = g;
        cur_sum += g;
        cur_cnt++;
        tick();
    endtask

    task automatic vsync_pulse(input int len);
        frame_t f;
        de_i    = 1'b0;
        vsync_i = 1'b1;
        f.e     = cyc + 1;
        f.sum   = cur_sum;
        f.cnt   = cur_cnt;
        fq.push_back(f);
        last_e  = cyc + 1;
        cur_sum = 0;
        cur_cnt = 0;
        repeat (len) tick();
        vsync_i = 1'b0;
    endtask

    task automatic frame(input int w, input int h, input logic [7:0] a, input logic [7:0] b);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) pixel(((x + y) % 2 == 0) ? a : b);
            idle(2);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n   = 1'b0;
        de_i    = 1'b0;
        vsync_i = 1'b0;
        cur_sum = 0;
        cur_cnt = 0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus and literal checks
    initial begin
        int prev_upd;
        int prev_err;
        do_reset(3);
        check("reset_thr", thr_o[0], 128);
        check("reset_mean", mean_o[0], 0);

        // first edge arms, second produces mean 100 - 20
        auto_en    = 1'b1;
        thr_offset = 8'hEC;
        idle(2);
        vsync_pulse(2);
        idle(2);
        frame(4, 4, 8'd100, 8'd100);
        prev_upd = upd_seen0;
        vsync_pulse(2);
        idle(14);
        check("t1_thr", thr_o[0], 80);
        check("t1_mean", mean_o[0], 100);
        check("t1_latency", last_upd_cyc0 - last_e, 11);
        check("t1_one_update", upd_seen0 - prev_upd, 1);

        thr_offset = 8'h00;
        frame(4, 4, 8'd10, 8'd30);
        vsync_pulse(2);
        idle(14);
        check("t2_thr_20", thr_o[0], 20);
        frame(4, 4, 8'd0, 8'd10);
        vsync_pulse(2);
        idle(14);
        check("t2_thr_min", thr_o[0], 16);
        check("t2_mean_5", mean_o[0], 5);

        // empty frame
        prev_upd = upd_seen0;
        prev_err = err_seen;
        vsync_pulse(2);
        idle(14);
        check("empty_err", err_seen - prev_err, 1);
        check("empty_no_upd", upd_seen0 - prev_upd, 0);
        check("empty_thr_hold", thr_o[0], 16);
        check("empty_mean_hold", mean_o[0], 5);

        // manual mode switched mid-frame
        for (int i = 0; i < 4; i++) pixel(8'd90);
        auto_en    = 1'b0;
        thr_manual = 8'd55;
        for (int i = 0; i < 4; i++) pixel(8'd90);
        idle(5);
        check("manual_no_early", thr_o[0], 16);
        vsync_pulse(2);
        idle(14);
        check("manual_thr0", thr_o[0], 55);
        check("manual_thr1", thr_o[1], 55);
        auto_en = 1'b1;

        // frame edge during division
        frame(4, 2, 8'd60, 8'd60);
        prev_err = err_seen;
        vsync_pulse(1);
        pixel(8'd90);
        pixel(8'd90);
        idle(1);
        vsync_pulse(1);
        idle(14);
        check("abort_err", err_seen - prev_err, 1);
        check("abort_mean", mean_o[0], 90);
        check("abort_thr", thr_o[0], 90);

        // reset during division, next edge only arms
        frame(4, 2, 8'd50, 8'd50);
        vsync_pulse(2);
        idle(3);
        do_reset(2);
        check("rst_thr", thr_o[0], 128);
        check("rst_mean", mean_o[0], 0);
        idle(14);
        frame(4, 2, 8'd70, 8'd70);
        prev_upd = upd_seen0;
        vsync_pulse(2);
        idle(14);
        check("rst_arm_no_upd", upd_seen0 - prev_upd, 0);
        check("rst_arm_thr", thr_o[1], 128);

        // smoothing from 128 towards 200
        upd_log1.delete();
        repeat (3) begin
            frame(4, 4, 8'd200, 8'd200);
            vsync_pulse(2);
            idle(14);
        end
        check("smooth_count", upd_log1.size(), 3);
        if (upd_log1.size() == 3) begin
            check("smooth_1", upd_log1[0], 146);
            check("smooth_2", upd_log1[1], 159);
            check("smooth_3", upd_log1[2], 169);
        end
        check("smooth_sh0", thr_o[0], 200);

        // randomized frames, settings and gaps (gaps may cause aborts)
        for (int it = 0; it < 16; it++) begin
            int w;
            int h;
            thr_offset = 8'($urandom_range(0, 255));
            thr_manual = 8'($urandom_range(0, 255));
            auto_en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) != 0) begin
                w = $urandom_range(1, 5);
                h = $urandom_range(1, 3);
                for (int y = 0; y < h; y++) begin
                    for (int x = 0; x < w; x++) pixel(8'($urandom_range(0, 255)));
                    idle($urandom_range(0, 2));
                end
            end
            vsync_pulse($urandom_range(1, 3));
            idle($urandom_range(0, 16));
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the bench must always terminate on its own.
    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
